// File: rtl/axi_addr_arb_pkg.sv
// Shared types and constants for the AXI address-channel arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package axi_addr_arb_pkg;

    localparam int LEN_W  = 9;   // burst length in beats, 1..256 legal
    localparam int SIZE_W = 8;   // bytes per beat, 1..128 legal

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Burst descriptor captured from the winning requester at grant time.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic              incr;
    } burst_t;

    // Next index in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_addr_rr_picker.sv
// Picks the first asserted request scanning upward (with wrap) from a start index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   req        in   NUM_REQ   pending request vector
//   start      in   ID_W      index where the scan begins
//   any        out  1         at least one request pending
//   win_idx    out  ID_W      index of the winner (0 when any=0)
//   win_onehot out  NUM_REQ   one-hot winner (all zero when any=0)
module axi_addr_rr_picker
    import axi_addr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic               any,
    output logic [ID_W-1:0]    win_idx,
    output logic [NUM_REQ-1:0] win_onehot
);

    always_comb begin : pick
        int   j;
        logic found;
        j          = 0;
        found      = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(start) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found         = 1'b1;
                win_idx       = ID_W'(j);
                win_onehot[j] = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/axi_addr_channel_arbiter.sv
// Shares one AXI address go/done channel among NUM_REQ requesters; one burst in flight at a time.
// Latency: req_valid in IDLE -> ch_go next cycle; ch_done -> req_done next cycle; >=2 cycles between grants.
// Backpressure: requesters hold req_valid until req_done; a high ch_done (stale or current) blocks new grants.
//
// Build option: define AXI_ADDR_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   req_valid/addr/len/size/incr    per-requester request, packed slice i = requester i
//   req_done, req_error             one-cycle completion pulse to the winner, with channel error status
//   busy, grant_id                  transaction in flight, current/last granted index
//   ch_go/address/burst_length/burst_size/increment   registered command to the channel
//   ch_done, ch_error               channel completion and error
module axi_addr_channel_arbiter
    import axi_addr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*SIZE_W-1:0] req_size,
    input  logic [NUM_REQ-1:0]        req_incr,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      req_error,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      ch_go,
    output logic [ADDR_W-1:0]         ch_address,
    output logic [LEN_W-1:0]          ch_burst_length,
    output logic [SIZE_W-1:0]         ch_burst_size,
    output logic                      ch_increment,
    input  logic                      ch_done,
    input  logic                      ch_error
);

    arb_state_t          state_q, state_d;
    logic                go_q, go_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    burst_t              burst_q, burst_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic [NUM_REQ-1:0]  oh_q, oh_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    // Unpack the flat request buses so the winner can be indexed directly.
    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    burst_t            burst_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign burst_a[i] = {req_len[i*LEN_W +: LEN_W], req_size[i*SIZE_W +: SIZE_W], req_incr[i]};
    end

    logic [ID_W-1:0] pick_start;

`ifdef AXI_ADDR_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_start = rr_ptr_q;
`else
    assign pick_start = '0;
`endif

    logic               pick_any;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_oh;

    axi_addr_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (req_valid),
        .start      (pick_start),
        .any        (pick_any),
        .win_idx    (pick_idx),
        .win_onehot (pick_oh)
    );

    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        gid_d   = gid_q;
        oh_d    = oh_q;
        done_d  = '0;
        err_d   = 1'b0;
`ifdef AXI_ADDR_ARB_RR_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                // A done still high from the previous burst must fall before the next go.
                if (pick_any && !ch_done) begin
                    addr_d  = addr_a[pick_idx];
                    burst_d = burst_a[pick_idx];
                    gid_d   = pick_idx;
                    oh_d    = pick_oh;
                    go_d    = 1'b1;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // Fields stay latched; requester changes are ignored until completion.
                if (ch_done) begin
                    go_d    = 1'b0;
                    done_d  = oh_q;
                    err_d   = ch_error;
`ifdef AXI_ADDR_ARB_RR_EN
                    rr_ptr_d = ID_W'(wrap_inc(int'(gid_q), NUM_REQ));
`endif
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                if (!ch_done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                go_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            go_q    <= 1'b0;
            addr_q  <= '0;
            burst_q <= '0;
            gid_q   <= '0;
            oh_q    <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AXI_ADDR_ARB_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            gid_q   <= gid_d;
            oh_q    <= oh_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef AXI_ADDR_ARB_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign ch_go           = go_q;
    assign ch_address      = addr_q;
    assign ch_burst_length = burst_q.len;
    assign ch_burst_size   = burst_q.size;
    assign ch_increment    = burst_q.incr;
    assign req_done        = done_q;
    assign req_error       = err_q;
    assign busy            = busy_q;
    assign grant_id        = gid_q;

endmodule
